chunked_subtractor: RTL and testbench

Multi-cycle integer subtractor computing `a - b` one chunk per clock, least-significant chunk first, with a registered borrow chained between chunks. It is the inverse-direction companion to the team's chunked adder: same chunk decomposition, but sequential, so the carry/borrow path per cycle is only `chunk_width` bits. It sits behind the integer ALU dispatch as a slow, small-area SUB unit with a req/ack handshake.

---
 rtl/chunked_arith_pkg.sv | 12 +
 rtl/chunked_subtractor_if.sv | 25 ++
 rtl/chunk_sub_step.sv | 17 +
 rtl/chunked_subtractor.sv | 112 +++++++++++
 tb/tb_chunked_subtractor.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/chunked_arith_pkg.sv
// Shared definitions for the chunked arithmetic units (adder, subtractor, multiplier front-end).
package chunked_arith_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chunked_state_e;

   localparam int default_data_width  = 32;
   localparam int default_chunk_width = 8;

endpackage

// File: rtl/chunked_subtractor_if.sv
// Request/acknowledge bus of the chunked subtractor.
interface chunked_subtractor_if #(
   parameter int data_width = 32
) ();

   logic                  req;
   logic [data_width-1:0] a;
   logic [data_width-1:0] b;
   logic                  busy;
   logic                  ack;
   logic [data_width-1:0] out;
   logic                  borrow;
   logic                  overflow;

   modport master (
      output req, a, b,
      input  busy, ack, out, borrow, overflow
   );

   modport slave (
      input  req, a, b,
      output busy, ack, out, borrow, overflow
   );

endinterface

// File: rtl/chunk_sub_step.sv
// One chunk of a - b as a + ~b + cin; cout is the inverted borrow.
module chunk_sub_step #(
   parameter int chunk_width = 8
) (
   input  logic [chunk_width-1:0] a_chunk,
   input  logic [chunk_width-1:0] b_chunk,
   input  logic                   cin,
   output logic [chunk_width-1:0] d,
   output logic                   cout
);

   // Widen by one bit so the carry-out falls out of the sum.
   always_comb begin
      {cout, d} = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{chunk_width{1'b0}}, cin};
   end

endmodule

// File: rtl/chunked_subtractor.sv
// Sequential subtractor: one chunk per clock, LSB chunk first, carry registered between chunks.
//
// state | meaning
// IDLE  | waiting for req; outputs hold the last result
// RUN   | processing chunk cnt of the latched operands
module chunked_subtractor
   import chunked_arith_pkg::*;
#(
   parameter int data_width  = default_data_width,
   parameter int chunk_width = default_chunk_width
) (
   input logic            clk,
   input logic            rst,
   chunked_subtractor_if.slave bus
);

   localparam int num_chunks = data_width / chunk_width;
   localparam int cnt_w      = (num_chunks > 1) ? $clog2(num_chunks) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks - 1);

   localparam logic [0:0] st_idle = 1'(IDLE);
   localparam logic [0:0] st_run  = 1'(RUN);

   logic [0:0]             state;
   logic [cnt_w-1:0]       cnt;
   logic [data_width-1:0]  a_q;
   logic [data_width-1:0]  b_q;
   logic [data_width-1:0]  res_q;
   logic [data_width-1:0]  res_next;
   logic                   carry;
   logic [chunk_width-1:0] a_chunk;
   logic [chunk_width-1:0] b_chunk;
   logic [chunk_width-1:0] d_chunk;
   logic                   c_chunk;
   logic                   last;
   logic [data_width-1:0]  out_q;
   logic                   borrow_q;
   logic                   ovf_q;
   logic                   ack_q;

   // Select the active chunk of each operand and merge the new difference chunk into the result.
   always_comb begin
      a_chunk  = a_q[int'(cnt) * chunk_width +: chunk_width];
      b_chunk  = b_q[int'(cnt) * chunk_width +: chunk_width];
      last     = (cnt == last_cnt);
      res_next = res_q;
      res_next[int'(cnt) * chunk_width +: chunk_width] = d_chunk;
   end

   chunk_sub_step #(
      .chunk_width (chunk_width)
   ) u_step (
      .a_chunk (a_chunk),
      .b_chunk (b_chunk),
      .cin     (carry),
      .d       (d_chunk),
      .cout    (c_chunk)
   );

   // FSM, chunk counter, operand latch and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= st_idle;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry    <= 1'b1;
         out_q    <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            st_idle: begin
               if (bus.req) begin
                  a_q   <= bus.a;
                  b_q   <= bus.b;
                  res_q <= '0;
                  carry <= 1'b1;
                  cnt   <= '0;
                  state <= st_run;
               end
            end
            st_run: begin
               res_q <= res_next;
               carry <= c_chunk;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  state    <= st_idle;
                  cnt      <= '0;
                  ack_q    <= 1'b1;
                  out_q    <= res_next;
                  borrow_q <= ~c_chunk;
                  // Signed overflow: operand signs differ and the result sign differs from a.
                  ovf_q    <= (a_q[data_width-1] != b_q[data_width-1]) &&
                              (d_chunk[chunk_width-1] != a_q[data_width-1]);
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

   assign bus.busy     = (state == st_run);
   assign bus.ack      = ack_q;
   assign bus.out      = out_q;
   assign bus.borrow   = borrow_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Scoreboard bench for chunked_subtractor (32-bit operands, 8-bit chunks).
module tb_chunked_subtractor;

   typedef struct packed {
      logic [31:0] diff;
      logic        borrow;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n_acks;
   int   n_pushed;
   exp_t sb[$];
   exp_t mon_e;

   chunked_subtractor_if #(.data_width(32)) bus ();

   chunked_subtractor #(
      .data_width  (32),
      .chunk_width (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] r;
      r        = a - b;
      e.diff   = r;
      e.borrow = (a < b);
      e.ovf    = (a[31] != b[31]) && (r[31] != a[31]);
      return e;
   endfunction

   // Drive a one-cycle req at a negedge; push the expected result when it will be accepted.
   task automatic do_req(input logic [31:0] a, input logic [31:0] b, input bit accepted);
      bus.req = 1'b1;
      bus.a   = a;
      bus.b   = b;
      if (accepted) begin
         sb.push_back(model(a, b));
         n_pushed++;
      end
      @(negedge clk);
      bus.req = 1'b0;
      bus.a   = $urandom;
      bus.b   = $urandom;
   endtask

   task automatic wait_ack(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.ack) seen = 1'b1;
      end
      check_val(tag, 64'(seen), 64'd1);
   endtask

   // Compare every completed result against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.ack) begin
         n_acks++;
         check_val("ack_has_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_val("out", 64'(bus.out), 64'(mon_e.diff));
            check_val("borrow", 64'(bus.borrow), 64'(mon_e.borrow));
            check_val("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_acks   = 0;
      n_pushed = 0;
      rst      = 1'b1;
      bus.req  = 1'b0;
      bus.a    = '0;
      bus.b    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_ack", 64'(bus.ack), 64'd0);
      check_val("rst_out", 64'(bus.out), 64'd0);
      check_val("rst_borrow", 64'(bus.borrow), 64'd0);
      check_val("rst_ovf", 64'(bus.overflow), 64'd0);
      @(negedge clk);

      // Basic, with exact busy/ack timing.
      do_req(32'd5, 32'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check_val("basic_busy", 64'(bus.busy), 64'd1);
         check_val("basic_no_ack", 64'(bus.ack), 64'd0);
      end
      @(negedge clk);
      check_val("basic_busy_fall", 64'(bus.busy), 64'd0);
      check_val("basic_ack", 64'(bus.ack), 64'd1);

      // Back-to-back: req driven in the ack cycle.
      do_req(32'd7, 32'd7, 1'b1);
      wait_ack("b2b_ack");
      @(negedge clk);

      do_req(32'd0, 32'd1, 1'b1);
      wait_ack("underflow_ack");
      @(negedge clk);
      do_req(32'h0001_0000, 32'd1, 1'b1);
      wait_ack("xchunk_ack");
      @(negedge clk);
      do_req(32'h8000_0000, 32'd1, 1'b1);
      wait_ack("ovf_ack");
      @(negedge clk);
      do_req(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_ack("ovf_pos_ack");
      @(negedge clk);

      // Reset mid-operation: the pending expectation is dropped, no ack may follow.
      do_req(32'h1234_5678, 32'h0000_0001, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      n_pushed--;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_busy", 64'(bus.busy), 64'd0);
      check_val("midrst_out", 64'(bus.out), 64'd0);
      check_val("midrst_borrow", 64'(bus.borrow), 64'd0);
      check_val("midrst_ovf", 64'(bus.overflow), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("midrst_no_ack", 64'(bus.ack), 64'd0);
      end
      do_req(32'd100, 32'd58, 1'b1);
      wait_ack("post_rst_ack");
      @(negedge clk);

      // Busy ignore: second req two cycles in must not start anything.
      do_req(32'd10, 32'd4, 1'b1);
      @(negedge clk);
      do_req(32'd1, 32'd1, 1'b0);
      wait_ack("ignore_ack");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_val("ignore_no_ack", 64'(bus.ack), 64'd0);
      end

      // A short burst of random operands.
      for (int i = 0; i < 6; i++) begin
         do_req($urandom, $urandom, 1'b1);
         wait_ack("rand_ack");
         @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check_val("sb_empty", 64'(sb.size()), 64'd0);
      check_val("ack_count", 64'(n_acks), 64'(n_pushed));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
